// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the pipeline stage registers of the
// ARM-subset processor.
//   COND_AL / COND_NV : "always" and undefined condition encodings.
//   CTRL_ALU_W        : width of the ALU control field.
//   ctrl_e_t          : E-stage control bundle.
//   CTRL_BUBBLE       : control bundle of a bubble (nothing happens).
//   kill_side_effects : clears every architectural side effect of a bundle.
//   sanitise_cond     : maps the undefined condition onto AL.
package pipeline_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int CTRL_ALU_W = 2;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  memto_reg;
    logic                  pc_src;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            flag_write;  // bit1 = N/Z, bit0 = C/V
    logic [CTRL_ALU_W-1:0] alu_control;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

  // Drop everything that could change architectural state (registers,
  // memory, PC, flags). Operand-routing fields are kept untouched.
  function automatic ctrl_e_t kill_side_effects(input ctrl_e_t c);
    ctrl_e_t r;
    r            = c;
    r.reg_write  = 1'b0;
    r.mem_write  = 1'b0;
    r.pc_src     = 1'b0;
    r.branch     = 1'b0;
    r.flag_write = 2'b00;
    return r;
  endfunction

  // The condition unit must never see the undefined encoding.
  function automatic logic [3:0] sanitise_cond(input logic [3:0] cond);
    return (cond == COND_NV) ? COND_AL : cond;
  endfunction

endpackage

// File: rtl/flopenrc.sv
// flopenrc: register with synchronous reset, synchronous clear and enable.
// Priority on each rising edge: reset > clr > en.
//   clk   : clock
//   reset : synchronous, active-high; loads RESET_VAL
//   en    : load d when high
//   clr   : synchronous clear; loads CLEAR_VAL, overrides en
//   d / q : data in / registered data out
module flopenrc #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= CLEAR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the decode controls, condition, operands, immediate and register
// numbers and presents them to the condition unit and ALU one cycle later.
//   clk, reset        : clock, synchronous active-high reset
//   StallE            : hold all E-stage state
//   FlushE            : load a bubble (wins over StallE)
//   *D inputs         : decode-stage controls, condition, data, addresses
//   *E outputs        : registered copies (condition never 4'b1111)
//   ValidE            : E holds a real instruction
//   IllegalCondE      : instruction in E arrived with the undefined condition
//   StallCount        : saturating count of stall cycles (stall without flush)
//   BubbleCount       : saturating count of flush cycles
// Every output comes straight from a flop; there is no D-to-E comb path.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ALUCTRL_W = CTRL_ALU_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 MemtoRegD,
  input  logic                 PCSrcD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           FlagWriteD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [3:0]           CondD,
  input  logic [WIDTH-1:0]     RD1D,
  input  logic [WIDTH-1:0]     RD2D,
  input  logic [WIDTH-1:0]     ExtImmD,
  input  logic [3:0]           RA1D,
  input  logic [3:0]           RA2D,
  input  logic [3:0]           WA3D,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 MemtoRegE,
  output logic                 PCSrcE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [1:0]           FlagWriteE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [3:0]           CondE,
  output logic [WIDTH-1:0]     RD1E,
  output logic [WIDTH-1:0]     RD2E,
  output logic [WIDTH-1:0]     ExtImmE,
  output logic [3:0]           RA1E,
  output logic [3:0]           RA2E,
  output logic [3:0]           WA3E,
  output logic                 ValidE,
  output logic                 IllegalCondE,
  output logic [CNT_W-1:0]     StallCount,
  output logic [CNT_W-1:0]     BubbleCount
);

  localparam int CTRL_W = $bits(ctrl_e_t);

  logic    load_en;
  logic    cond_nv;
  ctrl_e_t ctrl_raw;
  ctrl_e_t ctrl_next;
  ctrl_e_t ctrl_reg;
  logic [3:0] cond_next;
  logic [3:0] cond_reg;
  logic [3*WIDTH-1:0] data_reg;
  logic [11:0] addr_reg;
  logic [1:0]  status_reg;   // {valid, illegal_cond}

  // Flush is handled by the clr input of each register, so only the stall
  // needs to gate the enable.
  assign load_en = ~StallE;
  assign cond_nv = (CondD == COND_NV);

  always_comb begin
    ctrl_raw             = CTRL_BUBBLE;
    ctrl_raw.reg_write   = RegWriteD;
    ctrl_raw.mem_write   = MemWriteD;
    ctrl_raw.memto_reg   = MemtoRegD;
    ctrl_raw.pc_src      = PCSrcD;
    ctrl_raw.branch      = BranchD;
    ctrl_raw.alu_src     = ALUSrcD;
    ctrl_raw.flag_write  = FlagWriteD;
    ctrl_raw.alu_control = ALUControlD;
    // An instruction with the undefined condition still occupies the slot
    // (data and addresses load) but must not change any state.
    ctrl_next = cond_nv ? kill_side_effects(ctrl_raw) : ctrl_raw;
  end

  assign cond_next = sanitise_cond(CondD);

  flopenrc #(
    .WIDTH     (CTRL_W),
    .RESET_VAL (CTRL_BUBBLE),
    .CLEAR_VAL (CTRL_BUBBLE)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (FlushE),
    .d     (ctrl_next),
    .q     (ctrl_reg)
  );

  // Reset and bubble both park the condition at AL, never at NV.
  flopenrc #(
    .WIDTH     (4),
    .RESET_VAL (COND_AL),
    .CLEAR_VAL (COND_AL)
  ) u_cond (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (FlushE),
    .d     (cond_next),
    .q     (cond_reg)
  );

  flopenrc #(
    .WIDTH     (3*WIDTH),
    .RESET_VAL ('0),
    .CLEAR_VAL ('0)
  ) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (FlushE),
    .d     ({RD1D, RD2D, ExtImmD}),
    .q     (data_reg)
  );

  flopenrc #(
    .WIDTH     (12),
    .RESET_VAL ('0),
    .CLEAR_VAL ('0)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (FlushE),
    .d     ({RA1D, RA2D, WA3D}),
    .q     (addr_reg)
  );

  // Any load is a real instruction; the illegal flag follows the raw
  // condition of that load and is dropped by the next load or flush.
  flopenrc #(
    .WIDTH     (2),
    .RESET_VAL (2'b00),
    .CLEAR_VAL (2'b00)
  ) u_status (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (FlushE),
    .d     ({1'b1, cond_nv}),
    .q     (status_reg)
  );

  assign RegWriteE    = ctrl_reg.reg_write;
  assign MemWriteE    = ctrl_reg.mem_write;
  assign MemtoRegE    = ctrl_reg.memto_reg;
  assign PCSrcE       = ctrl_reg.pc_src;
  assign BranchE      = ctrl_reg.branch;
  assign ALUSrcE      = ctrl_reg.alu_src;
  assign FlagWriteE   = ctrl_reg.flag_write;
  assign ALUControlE  = ctrl_reg.alu_control;
  assign CondE        = cond_reg;
  assign RD1E         = data_reg[3*WIDTH-1:2*WIDTH];
  assign RD2E         = data_reg[2*WIDTH-1:WIDTH];
  assign ExtImmE      = data_reg[WIDTH-1:0];
  assign RA1E         = addr_reg[11:8];
  assign RA2E         = addr_reg[7:4];
  assign WA3E         = addr_reg[3:0];
  assign ValidE       = status_reg[1];
  assign IllegalCondE = status_reg[0];

  // Debug counters: index 0 = stall, index 1 = bubble. A cycle with both
  // StallE and FlushE counts only as a bubble.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg  [2];
  logic [CNT_W-1:0] cnt_next [2];

  assign cnt_inc = {FlushE, StallE & ~FlushE};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_next[gi] = cnt_reg[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  assign StallCount  = cnt_reg[0];
  assign BubbleCount = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, table-driven check of the ID/EX register,
// followed by hand-written runs for counter saturation and reset mid-flush.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int WIDTH = 32;
  localparam int ACW   = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             StallE, FlushE;
  logic             RegWriteD, MemWriteD, MemtoRegD, PCSrcD, BranchD, ALUSrcD;
  logic [1:0]       FlagWriteD;
  logic [ACW-1:0]   ALUControlD;
  logic [3:0]       CondD;
  logic [WIDTH-1:0] RD1D, RD2D, ExtImmD;
  logic [3:0]       RA1D, RA2D, WA3D;
  logic             RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE, ALUSrcE;
  logic [1:0]       FlagWriteE;
  logic [ACW-1:0]   ALUControlE;
  logic [3:0]       CondE;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;
  logic [3:0]       RA1E, RA2E, WA3E;
  logic             ValidE, IllegalCondE;
  logic [CNT_W-1:0] StallCount, BubbleCount;

  id_ex_stage #(.WIDTH(WIDTH), .ALUCTRL_W(ACW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD), .CondD(CondD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .FlagWriteE(FlagWriteE), .ALUControlE(ALUControlE), .CondE(CondE),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .ValidE(ValidE), .IllegalCondE(IllegalCondE),
    .StallCount(StallCount), .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  // ctrl packing used by the table: {RegWrite, MemWrite, MemtoReg, PCSrc,
  // Branch, ALUSrc, FlagWrite[1:0], ALUControl[1:0]}
  typedef struct {
    logic        stall;
    logic        flush;
    logic [9:0]  ctrl;
    logic [3:0]  cond;
    logic [95:0] data;   // {RD1, RD2, ExtImm}
    logic [11:0] addr;   // {RA1, RA2, WA3}
    logic [9:0]  e_ctrl;
    logic [3:0]  e_cond;
    logic [95:0] e_data;
    logic [11:0] e_addr;
    logic        e_valid;
    logic        e_illegal;
    logic [3:0]  e_stall;
    logic [3:0]  e_bubble;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_out();
    return {RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE, ALUSrcE, FlagWriteE, ALUControlE};
  endfunction

  task automatic drive(input logic st, input logic fl, input logic [9:0] c, input logic [3:0] cd,
                       input logic [95:0] d, input logic [11:0] a);
    StallE = st;
    FlushE = fl;
    {RegWriteD, MemWriteD, MemtoRegD, PCSrcD, BranchD, ALUSrcD, FlagWriteD, ALUControlD} = c;
    CondD = cd;
    {RD1D, RD2D, ExtImmD} = d;
    {RA1D, RA2D, WA3D} = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic [9:0] c, input logic [3:0] cd,
                              input logic [95:0] d, input logic [11:0] a,
                              input logic [9:0] ec, input logic [3:0] ecd, input logic [95:0] ed,
                              input logic [11:0] ea, input logic ev, input logic ei,
                              input logic [3:0] es, input logic [3:0] eb);
    vec_t v;
    v.stall = st; v.flush = fl; v.ctrl = c; v.cond = cd; v.data = d; v.addr = a;
    v.e_ctrl = ec; v.e_cond = ecd; v.e_data = ed; v.e_addr = ea;
    v.e_valid = ev; v.e_illegal = ei; v.e_stall = es; v.e_bubble = eb;
    return v;
  endfunction

  vec_t vecs[11];
  int   exp_cnt;

  initial begin
    logic [95:0] d0, d5, d7, d10;
    d0  = {32'h0000_00AA, 32'h0, 32'h0};
    d5  = {32'h0000_0011, 32'h0000_1234, 32'h0000_0022};
    d7  = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0FFF};
    d10 = {32'h0, 32'h5A5A_5A5A, 32'h8000_0000};

    // first load
    vecs[0]  = mk(0, 0, 10'h20C, 4'h0, d0, 12'h003,
                  10'h20C, 4'h0, d0, 12'h003, 1, 0, 4'd0, 4'd0);
    // three stalls while D changes: E holds
    vecs[1]  = mk(1, 0, 10'h3FF, 4'h5, {32'h55, 32'h66, 32'h77}, 12'h127,
                  10'h20C, 4'h0, d0, 12'h003, 1, 0, 4'd1, 4'd0);
    vecs[2]  = mk(1, 0, 10'h155, 4'h6, {32'h1, 32'h66, 32'h9}, 12'h321,
                  10'h20C, 4'h0, d0, 12'h003, 1, 0, 4'd2, 4'd0);
    vecs[3]  = mk(1, 0, 10'h2AA, 4'hF, {32'h0, 32'hFF, 32'h0}, 12'hFFF,
                  10'h20C, 4'h0, d0, 12'h003, 1, 0, 4'd3, 4'd0);
    // stall + flush: bubble only
    vecs[4]  = mk(1, 1, 10'h100, 4'h0, {32'h1, 32'h2, 32'h3}, 12'h456,
                  10'h000, 4'hE, 96'h0, 12'h000, 0, 0, 4'd3, 4'd1);
    // undefined condition: side effects killed, data loads
    vecs[5]  = mk(0, 0, 10'h3FF, 4'hF, d5, 12'h123,
                  10'h093, 4'hE, d5, 12'h123, 1, 1, 4'd3, 4'd1);
    // stall holds the illegal flag
    vecs[6]  = mk(1, 0, 10'h000, 4'h0, 96'h0, 12'h000,
                  10'h093, 4'hE, d5, 12'h123, 1, 1, 4'd4, 4'd1);
    // normal load clears the illegal flag
    vecs[7]  = mk(0, 0, 10'h277, 4'hA, d7, 12'hFED,
                  10'h277, 4'hA, d7, 12'hFED, 1, 0, 4'd4, 4'd1);
    // undefined again, then a flush clears it
    vecs[8]  = mk(0, 0, 10'h200, 4'hF, {32'h1, 32'h2, 32'h3}, 12'h111,
                  10'h000, 4'hE, {32'h1, 32'h2, 32'h3}, 12'h111, 1, 1, 4'd4, 4'd1);
    vecs[9]  = mk(0, 1, 10'h3FF, 4'h3, {32'h9, 32'h8, 32'h7}, 12'h789,
                  10'h000, 4'hE, 96'h0, 12'h000, 0, 0, 4'd4, 4'd2);
    vecs[10] = mk(0, 0, 10'h180, 4'h4, d10, 12'h9A0,
                  10'h180, 4'h4, d10, 12'h9A0, 1, 0, 4'd4, 4'd2);

    // reset for two cycles with all D inputs at 0
    reset = 1'b1;
    drive(0, 0, 10'h0, 4'h0, 96'h0, 12'h0);
    tick();
    tick();
    check("reset_ctrl", 128'(ctrl_out()), 128'h0);
    check("reset_cond", 128'(CondE), 128'hE);
    check("reset_data", 128'({RD1E, RD2E, ExtImmE}), 128'h0);
    check("reset_addr", 128'({RA1E, RA2E, WA3E}), 128'h0);
    check("reset_status", 128'({ValidE, IllegalCondE}), 128'h0);
    check("reset_counts", 128'({StallCount, BubbleCount}), 128'h0);
    $display("reset: CondE=%h ValidE=%b counts=%0d/%0d", CondE, ValidE, StallCount, BubbleCount);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].ctrl, vecs[i].cond, vecs[i].data, vecs[i].addr);
      tick();
      check($sformatf("v%0d_ctrl", i), 128'(ctrl_out()), 128'(vecs[i].e_ctrl));
      check($sformatf("v%0d_cond", i), 128'(CondE), 128'(vecs[i].e_cond));
      check($sformatf("v%0d_data", i), 128'({RD1E, RD2E, ExtImmE}), 128'(vecs[i].e_data));
      check($sformatf("v%0d_addr", i), 128'({RA1E, RA2E, WA3E}), 128'(vecs[i].e_addr));
      check($sformatf("v%0d_valid", i), 128'(ValidE), 128'(vecs[i].e_valid));
      check($sformatf("v%0d_illegal", i), 128'(IllegalCondE), 128'(vecs[i].e_illegal));
      check($sformatf("v%0d_stallcnt", i), 128'(StallCount), 128'(vecs[i].e_stall));
      check($sformatf("v%0d_bubblecnt", i), 128'(BubbleCount), 128'(vecs[i].e_bubble));
      $display("vec %0d: stall=%b flush=%b cond=%h -> CondE=%h ValidE=%b Ill=%b cnt=%0d/%0d",
               i, vecs[i].stall, vecs[i].flush, vecs[i].cond, CondE, ValidE, IllegalCondE,
               StallCount, BubbleCount);
    end

    // stall for 20 cycles: StallCount saturates at 15, E state holds
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 10'(i * 37), 4'(i), {32'(i), 32'(i * 3), 32'(i * 7)}, 12'(i * 5));
      tick();
      exp_cnt = (4 + i > 15) ? 15 : 4 + i;
      check($sformatf("stall%0d_cnt", i), 128'(StallCount), 128'(exp_cnt));
      check($sformatf("stall%0d_hold", i), 128'({CondE, RD2E}), 128'({4'h4, 32'h5A5A_5A5A}));
      $display("stall run %0d: StallCount=%0d BubbleCount=%0d", i, StallCount, BubbleCount);
    end
    check("stall_run_bubble", 128'(BubbleCount), 128'd2);

    // flush for 20 cycles: BubbleCount saturates at 15
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 10'h3FF, 4'hF, {96{1'b1}}, 12'hFFF);
      tick();
      exp_cnt = (2 + i > 15) ? 15 : 2 + i;
      check($sformatf("flush%0d_cnt", i), 128'(BubbleCount), 128'(exp_cnt));
      check($sformatf("flush%0d_bubble", i), 128'({CondE, ValidE, IllegalCondE, ctrl_out()}),
            128'({4'hE, 1'b0, 1'b0, 10'h000}));
      $display("flush run %0d: StallCount=%0d BubbleCount=%0d", i, StallCount, BubbleCount);
    end
    check("flush_run_stall", 128'(StallCount), 128'd15);

    // reset in the middle of a flush run clears the counters on that edge
    reset = 1'b1;
    tick();
    check("midrst_counts", 128'({StallCount, BubbleCount}), 128'h0);
    check("midrst_state", 128'({CondE, ValidE}), 128'({4'hE, 1'b0}));
    $display("reset mid-flush: counts=%0d/%0d", StallCount, BubbleCount);
    reset = 1'b0;
    tick();
    check("postrst_bubble", 128'({StallCount, BubbleCount}), 128'({4'd0, 4'd1}));
    $display("flush after reset: counts=%0d/%0d", StallCount, BubbleCount);
    drive(1, 0, 10'h0, 4'h0, 96'h0, 12'h0);
    tick();
    check("postrst_stall", 128'({StallCount, BubbleCount}), 128'({4'd1, 4'd1}));
    $display("stall after reset: counts=%0d/%0d", StallCount, BubbleCount);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
